// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit with ready/valid handshakes and flush
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic            is_word,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] hi, lo, d, res;
  logic [2:0] op;
  logic w, neg;
  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction
  logic wi, sg1, sg2, s1, s2, accept, illegal, dz, ovf, special;
  logic [XLEN-1:0] x1, x2, m1, m2, mn, dvd, spec_res;
  logic [XLEN:0] sum, sh, df;
  logic ge;
  logic [2*XLEN-1:0] mul_nx, div_nx, p, pw, pn;
  logic [XLEN-1:0] v, vn, fix_res;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state == CALC || state == FIX;
  assign result    = res;
  assign accept    = in_valid & in_ready & ~flush;
  // Operand conditioning: word extension, magnitudes and the early-out special cases
  always_comb begin
    wi       = is_word & (XLEN == 64);
    sg1      = func3 == 3'b001 || func3 == 3'b010 || func3 == 3'b100 || func3 == 3'b110;
    sg2      = func3 == 3'b001 || func3 == 3'b100 || func3 == 3'b110;
    x1       = wi ? (sg1 ? sx(rs1[31:0]) : XLEN'(rs1[31:0])) : rs1;
    x2       = wi ? (sg2 ? sx(rs2[31:0]) : XLEN'(rs2[31:0])) : rs2;
    s1       = sg1 & x1[XLEN-1];
    s2       = sg2 & x2[XLEN-1];
    m1       = s1 ? -x1 : x1;
    m2       = s2 ? -x2 : x2;
    mn       = wi ? sx(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    dvd      = wi ? sx(rs1[31:0]) : rs1;
    illegal  = wi & ~func3[2] & |func3[1:0];
    dz       = func3[2] & (x2 == '0);
    ovf      = func3[2] & ~func3[0] & (x1 == mn) & (&x2);
    special  = illegal | dz | ovf;
    spec_res = illegal ? '0 : dz ? (func3[1] ? dvd : '1) : (func3[1] ? '0 : dvd);
  end
  // One shift-add multiply step, one restoring divide step, and final sign/width fix-up
  always_comb begin
    sum     = {1'b0, hi} + {1'b0, d};
    sh      = {hi, lo[XLEN-1]};
    df      = sh - {1'b0, d};
    ge      = sh >= {1'b0, d};
    mul_nx  = lo[0] ? {sum, lo[XLEN-1:1]} : {1'b0, hi, lo[XLEN-1:1]};
    div_nx  = {ge ? df[XLEN-1:0] : sh[XLEN-1:0], lo[XLEN-2:0], ge};
    p       = {hi, lo};
    pw      = w ? p >> 32 : p;
    pn      = neg ? -pw : pw;
    v       = op[1] ? hi : lo;
    vn      = neg ? -v : v;
    fix_res = op[2] ? (w ? sx(vn[31:0]) : vn) :
              op[1:0] == 2'b00 ? (w ? sx(pn[31:0]) : pn[XLEN-1:0]) : pn[2*XLEN-1:XLEN];
  end
  // Next state; flush wins over accept and acknowledge
  always_comb begin
    state_nx = flush ? IDLE :
               state == IDLE ? (accept ? (special ? DONE : CALC) : IDLE) :
               state == CALC ? (cnt == '0 ? FIX : CALC) :
               state == FIX  ? DONE : (out_ready ? IDLE : DONE);
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Datapath: load on accept, iterate in CALC, latch the result in FIX
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi  <= '0;
      lo  <= '0;
      d   <= '0;
      res <= '0;
      op  <= '0;
      w   <= 1'b0;
      neg <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      op  <= func3;
      w   <= wi;
      neg <= func3[2] & func3[1] ? s1 : s1 ^ s2;
      hi  <= '0;
      lo  <= func3[2] ? (wi ? m1 << 32 : m1) : m2;
      d   <= func3[2] ? m2 : m1;
      cnt <= wi ? CW'(31) : CW'(XLEN-1);
      if (special) res <= spec_res;
    end else if (state == CALC) begin
      cnt      <= cnt - 1'b1;
      {hi, lo} <= op[2] ? div_nx : mul_nx;
    end else if (state == FIX && !flush) begin
      res <= fix_res;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, is_word = 0, out_ready = 0;
  logic [2:0] func3 = '0;
  logic [63:0] rs1 = '0, rs2 = '0;
  logic in_ready, out_valid, busy;
  logic [63:0] result;
  int n = 0, fails = 0;

  muldiv_unit #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .func3(func3), .is_word(is_word), .rs1(rs1), .rs2(rs2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic        wd;
    logic [63:0] a, b, exp;
    int          lat;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) chk("valid_ready_excl", 64'(out_valid & in_ready), 64'd0);

  task automatic issue(input logic [2:0] f, input logic wd, input logic [63:0] a, input logic [63:0] b);
    func3 = f; is_word = wd; rs1 = a; rs2 = b; in_valid = 1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      in_valid = 0;
      if (out_valid) break;
    end
  endtask

  task automatic ack();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  int cyc;
  logic [63:0] last;

  initial begin
    vecs[0]  = '{"div_neg7_2",   3'b100, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    vecs[1]  = '{"rem_neg7_2",   3'b110, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vecs[2]  = '{"mulhu_max_2",  3'b011, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 66};
    vecs[3]  = '{"mul_max_2",    3'b000, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 66};
    vecs[4]  = '{"mulhsu_m1_2",  3'b010, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vecs[5]  = '{"divu_by0",     3'b101, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[6]  = '{"remu_by0",     3'b111, 0, 64'd5, 64'd0, 64'd5, 1};
    vecs[7]  = '{"div_ovf",      3'b100, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[8]  = '{"rem_ovf",      3'b110, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[9]  = '{"divw_ovf",     3'b100, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[10] = '{"mulw",         3'b000, 1, 64'h1_0000_0003, 64'h7FFF_FFFF, 64'h0000_0000_7FFF_FFFD, 34};
    vecs[11] = '{"mulh_neg3_5",  3'b001, 0, -64'sd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vecs[12] = '{"mulh_2p62_4",  3'b001, 0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 66};
    vecs[13] = '{"remw_neg7_2",  3'b110, 1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[14] = '{"mulhw_illegal",3'b001, 1, 64'd7, 64'd9, 64'd0, 1};
    vecs[15] = '{"divuw_max_1",  3'b101, 1, 64'hAB00_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34};

    #12 chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      chk({vecs[i].name, "_in_ready"}, 64'(in_ready), 64'd1);
      issue(vecs[i].f, vecs[i].wd, vecs[i].a, vecs[i].b);
      wait_done(cyc);
      chk({vecs[i].name, "_latency"}, 64'(cyc), 64'(vecs[i].lat));
      chk({vecs[i].name, "_result"}, result, vecs[i].exp);
      ack();
    end
    last = 64'hFFFF_FFFF_FFFF_FFFF;

    issue(3'b000, 1, 64'h1_0000_0003, 64'h7FFF_FFFF);
    wait_done(cyc);
    chk("hold_latency", 64'(cyc), 64'd34);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_result", result, 64'h7FFF_FFFD);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("ack_in_ready", 64'(in_ready), 64'd1);
    chk("ack_out_valid", 64'(out_valid), 64'd0);
    last = 64'h7FFF_FFFD;

    issue(3'b101, 0, 64'd1000, 64'd3);
    @(negedge clk);
    in_valid = 0;
    repeat (19) @(negedge clk);
    chk("pre_flush_busy", 64'(busy), 64'd1);
    flush = 1;
    issue(3'b101, 0, 64'd100, 64'd7);
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_result_kept", result, last);
    flush = 0;
    wait_done(cyc);
    chk("reoffer_latency", 64'(cyc), 64'd66);
    chk("reoffer_result", result, 64'd14);
    ack();

    issue(3'b100, 0, 64'd77, 64'd5);
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    issue(3'b110, 0, 64'd77, 64'd5);
    wait_done(cyc);
    chk("post_rst_latency", 64'(cyc), 64'd66);
    chk("post_rst_rem", result, 64'd2);
    ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
